// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder step per clock, LSB first.
// Operands are captured on start; {cout, sum} is valid while done is high.
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | one bit step per edge, WIDTH edges in total
// DONE  | sum/cout valid for one cycle; start here chains the next addition
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic [WIDTH-1:0] sum_shift;
  logic             carry;
  logic             cout_reg;
  logic [CW-1:0]    cnt;
  logic             bit_sum;
  logic             bit_carry;
  logic             last_step;
  logic             accept;

  always_comb begin
    bit_sum   = a_reg[0] ^ b_reg[0] ^ carry;
    bit_carry = (a_reg[0] & b_reg[0]) | (a_reg[0] & carry) | (b_reg[0] & carry);
    last_step = (cnt == LAST);
    accept    = start && ((state == IDLE) || (state == DONE));
    // Written as shift-then-overwrite so WIDTH=1 needs no zero-width slice.
    sum_shift            = sum_reg >> 1;
    sum_shift[WIDTH-1]   = bit_sum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last_step) state_next = DONE;
      DONE:    state_next = start ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // sum_reg and cout_reg are left alone on accept so the previous result
  // stays visible until the first bit step of the next addition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      sum_reg  <= '0;
      carry    <= 1'b0;
      cout_reg <= 1'b0;
      cnt      <= '0;
    end else if (accept) begin
      a_reg <= a;
      b_reg <= b;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (state == SHIFT) begin
      a_reg   <= a_reg >> 1;
      b_reg   <= b_reg >> 1;
      sum_reg <= sum_shift;
      carry   <= bit_carry;
      cnt     <= cnt + CW'(1);
      if (last_step) cout_reg <= bit_carry;
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);
  assign sum  = sum_reg;
  assign cout = cout_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboarded bench for serial_adder: WIDTH=8 directed vectors and an
// exhaustive WIDTH=4 sweep; a negedge monitor pops expectations on done.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, start4;
  logic [7:0] a8, b8, sum8;
  logic [3:0] a4, b4, sum4;
  logic       busy8, done8, cout8;
  logic       busy4, done4, cout4;

  logic [8:0] q8[$];
  logic [4:0] q4[$];
  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) check("done8_unexpected", 32'(done8), 32'd0);
      else check("sum8", 32'({cout8, sum8}), 32'(q8.pop_front()));
    end
    if (done4) begin
      if (q4.size() == 0) check("done4_unexpected", 32'(done4), 32'd0);
      else check("sum4", 32'({cout4, sum4}), 32'(q4.pop_front()));
    end
  end

  // Called #1 after the accepting edge; done must rise 9 edges after accept
  // (counting that edge) with busy high for the 8 cycles in between.
  task automatic measure8(input string nm);
    int edges = 1;
    int busy_cnt = 0;
    while (!done8 && edges < 30) begin
      busy_cnt += int'(busy8);
      @(posedge clk); #1;
      edges++;
    end
    check({nm, "_latency"}, 32'(edges), 32'd9);
    check({nm, "_busy_cycles"}, 32'(busy_cnt), 32'd8);
  endtask

  task automatic idle_check8(input string nm);
    @(posedge clk); #1;
    check({nm, "_idle"}, 32'({busy8, done8}), 32'd0);
  endtask

  task automatic issue8(input string nm, input logic [7:0] va, input logic [7:0] vb,
                        input logic [8:0] exp);
    @(negedge clk);
    a8 = va; b8 = vb; start8 = 1'b1;
    q8.push_back(exp);
    @(posedge clk); #1;
    start8 = 1'b0;
    measure8(nm);
    idle_check8(nm);
  endtask

  initial begin
    int edges;
    int done_seen;
    rst = 1'b0; start8 = 1'b0; start4 = 1'b0;
    a8 = '0; b8 = '0; a4 = '0; b4 = '0;
    #1 rst = 1'b1;
    #2;
    check("rst_outputs8", 32'({busy8, done8, cout8, sum8}), 32'd0);
    check("rst_outputs4", 32'({busy4, done4, cout4, sum4}), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    issue8("zero",  8'h00, 8'h00, 9'h000);
    issue8("ff_01", 8'hFF, 8'h01, 9'h100);
    issue8("a5_5a", 8'hA5, 8'h5A, 9'h0FF);

    // start held high through SHIFT with new operands: only taken at DONE
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h20; start8 = 1'b1;
    q8.push_back(9'h030);
    @(posedge clk); #1;
    a8 = 8'hFF; b8 = 8'hFF;
    measure8("held_start");
    q8.push_back(9'h1FE);
    @(posedge clk); #1;
    start8 = 1'b0;
    check("held_rearm_busy", 32'(busy8), 32'd1);
    measure8("held_second");
    idle_check8("held_second");

    // back-to-back: start raised during the DONE cycle
    @(negedge clk);
    a8 = 8'hC3; b8 = 8'h3C; start8 = 1'b1;
    q8.push_back(9'h0FF);
    @(posedge clk); #1;
    start8 = 1'b0;
    measure8("b2b_first");
    a8 = 8'h80; b8 = 8'h80; start8 = 1'b1;
    q8.push_back(9'h100);
    @(posedge clk); #1;
    start8 = 1'b0;
    check("b2b_no_idle", 32'({busy8, done8}), 32'd2);
    measure8("b2b_second");
    idle_check8("b2b_second");

    // reset after three bit steps: async clear, no done, start ignored
    @(negedge clk);
    a8 = 8'h3C; b8 = 8'h0F; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_outputs", 32'({busy8, done8, cout8, sum8}), 32'd0);
    start8 = 1'b1; a8 = 8'hFF;
    @(posedge clk); #1;
    check("rst_ignores_start", 32'({busy8, done8}), 32'd0);
    @(negedge clk);
    rst = 1'b0; start8 = 1'b0;
    done_seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      done_seen += int'(done8);
    end
    check("midrst_no_done", 32'(done_seen), 32'd0);
    issue8("after_rst", 8'h3C, 8'h0F, 9'h04B);

    // exhaustive WIDTH=4; each new start lands in the DONE cycle of the last
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        @(negedge clk);
        a4 = 4'(ia); b4 = 4'(ib); start4 = 1'b1;
        q4.push_back(5'(ia + ib));
        @(posedge clk); #1;
        start4 = 1'b0;
        edges = 1;
        while (!done4 && edges < 12) begin
          @(posedge clk); #1;
          edges++;
        end
        check("latency4", 32'(edges), 32'd5);
      end
    end

    repeat (3) @(posedge clk);
    #1;
    check("q8_drained", 32'(q8.size()), 32'd0);
    check("q4_drained", 32'(q4.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and sum width in bits; legal range 1 to 32.
REQ-002 The block SHALL have port clk  input  1  system clock, all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port start  input  1  request to add the operands presented on a and b.
REQ-005 The block SHALL have port a  input  WIDTH  first operand, sampled only when start is accepted.
REQ-006 The block SHALL have port b  input  WIDTH  second operand, sampled only when start is accepted.
REQ-007 The block SHALL have port busy  output  1  high while an addition is in progress.
REQ-008 The block SHALL have port done  output  1  single-cycle pulse marking that sum and cout are valid.
REQ-009 The block SHALL have port sum  output  WIDTH  registered result, a+b modulo 2^WIDTH.
REQ-010 The block SHALL have port cout  output  1  registered carry-out of the addition.

Function
REQ-011 The block SHALL implement three states: IDLE, SHIFT and DONE.
REQ-012 The block SHALL accept start on a rising edge when the state is IDLE or DONE, as follows:
- capture a and b into shift registers
- clear the internal carry flip-flop and the bit counter
- enter SHIFT.
REQ-013 The block SHALL ignore start while in SHIFT, leaving the operand registers, counter and carry unchanged.
REQ-014 Each SHIFT-state edge SHALL perform one full-adder step on the operand LSBs and the carry flip-flop, as follows:
- sum bit = a0 XOR b0 XOR c
- next carry = majority(a0, b0, c)
- shift both operand registers right by one bit
- shift the sum bit into the MSB of the sum register, with the sum register shifting right
- increment the counter.
REQ-015 On the WIDTH-th SHIFT-state edge, the block SHALL:
- perform the final bit step
- load cout with the final carry
- enter DONE.
REQ-016 busy SHALL be high exactly while the state is SHIFT, i.e. for WIDTH cycles per addition.
REQ-017 done SHALL be high exactly while the state is DONE, one cycle, beginning WIDTH+1 rising edges after the edge that accepted start.
REQ-018 From DONE, the block SHALL return to IDLE on the next edge if start is low, or re-enter SHIFT with new operands if start is high.
REQ-019 The block SHALL hold sum and cout stable from DONE until the first SHIFT edge of the next addition.
- sum and cout are not guaranteed meaningful during SHIFT.
- The verifier SHALL check them only when done=1.
REQ-020 The counter SHALL be wide enough to count to WIDTH without wrap, at minimum clog2(WIDTH+1) bits.
REQ-021 For WIDTH=1, the block SHALL spend one cycle in SHIFT and then pulse done.

Reset
REQ-022 Asserting rst SHALL immediately, without waiting for clk:
- force state to IDLE
- set busy=0, done=0, sum=0, cout=0
- clear the carry flip-flop, counter and operand registers.
REQ-023 Asserting rst during SHIFT or DONE SHALL abort the operation with no done pulse.
REQ-024 While rst is high, the block SHALL ignore start.
REQ-025 The first start accepted after rst deasserts SHALL behave per REQ-012.

Verification
REQ-026 The bench SHALL cover: WIDTH=8, a=8'h00, b=8'h00, pulse start -> busy high 8 cycles, then done pulse with sum=8'h00, cout=0.
REQ-027 The bench SHALL cover: a=8'hFF, b=8'h01 -> done after 9 edges with sum=8'h00, cout=1; also a=8'hA5, b=8'h5A -> sum=8'hFF, cout=0.
REQ-028 The bench SHALL cover: start a=8'h10, b=8'h20, then hold start high with a=8'hFF, b=8'hFF during SHIFT -> single done with sum=8'h30, cout=0, and the second pair is not taken until DONE.
REQ-029 The bench SHALL cover: back-to-back start with start high in the DONE cycle (a=8'h80, b=8'h80) -> second done 9 edges later with sum=8'h00, cout=1, and no IDLE cycle between.
REQ-030 The bench SHALL cover: rst pulsed mid-SHIFT (after 3 bit steps) -> busy, done, sum and cout go to 0 asynchronously, no done pulse, and the next start computes correctly.
REQ-031 The bench SHALL cover exhaustive self-check: WIDTH=4, all 256 (a,b) pairs -> {cout,sum} equals a+b at every done pulse.
